// File: rtl/fixed_point_unsigned_long_divider.sv
// Multi-cycle unsigned fixed-point divider: Q = (dividend << FRAC) / divisor,
// one restoring-division step per clock, valid/ready on both sides.
module fixed_point_unsigned_long_divider #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int unsigned QW = WIDTH + FRAC;
  localparam int unsigned CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  // Numerator bits shift out of the top while quotient bits shift in below.
  logic [QW-1:0]    nq_q, nq_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             ready_d, valid_d, busy_d, dbz_d, ovf_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;

  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             fits;
  logic [WIDTH-1:0] step_rem;
  logic [QW-1:0]    step_nq;
  logic             step_ovf;
  logic             accept;
  logic             last_bit;

  // One restoring step; the remainder is always below the divisor, so the
  // sign bit of the trial subtraction tells whether the divisor fits.
  always_comb begin
    rem_shift = {rem_q, nq_q[QW-1]};
    rem_sub   = rem_shift - {1'b0, div_q};
    fits      = ~rem_sub[WIDTH];
    step_rem  = fits ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    step_nq   = {nq_q[QW-2:0], fits};
    step_ovf  = (step_nq >> WIDTH) != '0;
  end

  assign accept   = i_valid && (state == IDLE);
  assign last_bit = (cnt_q == CW'(1));

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (i_divisor == '0) ? DONE : BUSY;
      BUSY: if (last_bit) state_next = DONE;
      DONE: if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of datapath and registered outputs
  always_comb begin
    nq_d        = nq_q;
    rem_d       = rem_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    quotient_d  = o_quotient;
    remainder_d = o_remainder;
    dbz_d       = o_div_by_zero;
    ovf_d       = o_overflow;
    ready_d     = (state_next == IDLE);
    valid_d     = (state_next == DONE);
    busy_d      = (state_next == BUSY);
    case (state)
      IDLE: begin
        if (accept) begin
          nq_d  = QW'(i_dividend) << FRAC;
          rem_d = '0;
          div_d = i_divisor;
          cnt_d = CW'(QW);
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (i_divisor == '0) begin
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
          end
        end
      end
      BUSY: begin
        nq_d  = step_nq;
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        if (last_bit) begin
          quotient_d  = step_ovf ? '1 : step_nq[WIDTH-1:0];
          remainder_d = step_rem;
          ovf_d       = step_ovf;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset discards any pending result
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      nq_q          <= '0;
      rem_q         <= '0;
      div_q         <= '0;
      cnt_q         <= '0;
      o_ready       <= 1'b1;
      o_valid       <= 1'b0;
      o_busy        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      nq_q          <= nq_d;
      rem_q         <= rem_d;
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      o_ready       <= ready_d;
      o_valid       <= valid_d;
      o_busy        <= busy_d;
      o_quotient    <= quotient_d;
      o_remainder   <= remainder_d;
      o_div_by_zero <= dbz_d;
      o_overflow    <= ovf_d;
    end
  end

endmodule
